// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default timing constants and helpers for the PLL reset sequencer
package pll_seq_pkg;
  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;
  localparam int PLL_RST_CYCLES_DEF      = 16;
  localparam int LOCK_TIMEOUT_CYCLES_DEF = 2500;
  localparam int LOCK_STABLE_CYCLES_DEF  = 256;
  localparam int CNT_W_DEF               = 12;
  localparam int STAT_W                  = 8;
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchronizer with synchronous active-high reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk)
    if (rst) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives PLL reset, qualifies lock and releases SoC reset after lock is stable
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int CNT_W               = CNT_W_DEF
) (
  input  logic              input_clk,
  input  logic              reset,
  input  logic              pll_locked,
  input  logic              sw_reset_req,
  output logic              pll_reset,
  output logic              soc_reset,
  output logic              pll_ok,
  output logic [STAT_W-1:0] relock_count,
  output logic [STAT_W-1:0] timeout_count
);
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic lock_s, pr_done, to_done, st_done, to_hit, rl_hit;
  sync_2ff u_lock_sync (
    .clk(input_clk),
    .rst(reset),
    .d  (pll_locked),
    .q  (lock_s)
  );
  assign pr_done = cnt == CNT_W'(PLL_RST_CYCLES - 1);
  assign to_done = cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  assign st_done = cnt == CNT_W'(LOCK_STABLE_CYCLES - 1);
  // a software restart suppresses the statistics of the transition it overrides
  assign to_hit = !sw_reset_req && state == WAIT_LOCK && !lock_s && to_done;
  assign rl_hit = !sw_reset_req && state == RUN && !lock_s;
  always_comb begin
    state_n = state;
    case (state)
      PLL_RST:   state_n = pr_done ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: state_n = lock_s ? STABLE : to_done ? PLL_RST : WAIT_LOCK;
      STABLE:    state_n = !lock_s ? WAIT_LOCK : st_done ? RUN : STABLE;
      RUN:       state_n = lock_s ? RUN : PLL_RST;
      default:   state_n = PLL_RST;
    endcase
    if (sw_reset_req) state_n = PLL_RST;
  end
  always_ff @(posedge input_clk)
    if (reset) begin
      state         <= PLL_RST;
      cnt           <= '0;
      pll_reset     <= 1'b1;
      soc_reset     <= 1'b1;
      pll_ok        <= 1'b0;
      relock_count  <= '0;
      timeout_count <= '0;
    end else begin
      state         <= state_n;
      cnt           <= (sw_reset_req || state_n != state || state_n == RUN) ? '0 : cnt + 1'b1;
      pll_reset     <= state_n == PLL_RST;
      soc_reset     <= state_n != RUN;
      pll_ok        <= state_n == RUN;
      if (to_hit) timeout_count <= sat_inc(timeout_count);
      if (rl_hit) relock_count <= sat_inc(relock_count);
    end
endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the ECP5 PLL from the reference-clock side: drives the PLL reset, qualifies its asynchronous lock output, and releases the SoC reset only after lock has been stable.
- Runs on the 25 MHz board clock; the PLL output clock is never used here.
- On lock loss or timeout it re-asserts SoC reset and restarts the PLL.
- Sits at top level between the board clock/reset pins, the PLL wrapper (its reset input and locked output) and the soc_clk-domain reset synchronizer.

Parameters:
- PLL_RST_CYCLES, 16: number of input_clk cycles pll_reset is held high per attempt (min 1).
- LOCK_TIMEOUT_CYCLES, 2500: cycles to wait for lock before restarting the PLL (100 us at 25 MHz; min 1).
- LOCK_STABLE_CYCLES, 256: consecutive cycles lock must stay high before SoC reset is released (min 1).
- CNT_W, 12: width of the shared cycle counter; must hold max(all three above) - 1.

Ports:
- input_clk  in  1  board reference clock, 25 MHz; sole clock.
- reset  in  1  synchronous, active-high block reset.
- pll_locked  in  1  PLL lock, asynchronous to input_clk.
- sw_reset_req  in  1  one-cycle request to restart the PLL and the SoC.
- pll_reset  out  1  drives the PLL reset input; 1 = PLL held in reset.
- soc_reset  out  1  SoC reset request, active-high; re-synchronized into soc_clk by the consumer.
- pll_ok  out  1  1 only in RUN.
- relock_count  out  8  saturating count of lock losses seen in RUN.
- timeout_count  out  8  saturating count of lock timeouts.

Behaviour:
- One clock, input_clk. reset is synchronous and active-high and has priority over everything.
- While reset=1:
  - state=PLL_RST and counter=0.
  - pll_reset=1, soc_reset=1, pll_ok=0.
  - relock_count=0, timeout_count=0.
  - Both synchronizer flops = 0.
- Lock synchronizer: pll_locked passes through a 2-flop synchronizer to give lock_s.
  - pll_locked sampled 1 at edge k gives lock_s=1 visible to the FSM at edge k+2.
- All outputs are registered and decoded from the next state, so they change on the same edge as the state. No combinational paths from inputs to outputs.
- Counter: CNT_W bits; cleared on every state change; otherwise increments by 1 per cycle.
- PLL_RST (pll_reset=1, soc_reset=1, pll_ok=0):
  - counter==PLL_RST_CYCLES-1 -> WAIT_LOCK.
- WAIT_LOCK (pll_reset=0, soc_reset=1):
  - lock_s=1 -> STABLE.
  - else counter==LOCK_TIMEOUT_CYCLES-1 -> PLL_RST, and timeout_count+1 (saturates at 255).
- STABLE (pll_reset=0, soc_reset=1):
  - lock_s=0 -> WAIT_LOCK (glitch; counters not incremented).
  - else counter==LOCK_STABLE_CYCLES-1 -> RUN.
- RUN (pll_reset=0, soc_reset=0, pll_ok=1):
  - lock_s=0 -> PLL_RST, and relock_count+1 (saturates at 255).
  - Counter is held at 0 in RUN.
- sw_reset_req=1 in any state -> PLL_RST, counter=0; no statistics change.
  - Simultaneous with a lock loss in RUN: sw_reset_req wins and relock_count is not incremented.
- Latency: if pll_locked is first sampled 1 at edge k while in WAIT_LOCK and stays 1, soc_reset falls at edge k+2+LOCK_STABLE_CYCLES.
- Boundary cases:
  - Lock already high on entry to WAIT_LOCK: goes to STABLE on the next edge.
  - Lock arriving on the timeout cycle: lock takes priority (STABLE, no timeout counted).
  - Saturated counters hold at 255.
  - reset asserted mid-sequence behaves exactly as at power-up.

Decomposition:
- Shared package pll_seq_pkg:
  - state enum: PLL_RST=2'd0, WAIT_LOCK=2'd1, STABLE=2'd2, RUN=2'd3.
  - Default cycle constants and CNT_W.
  - STAT_W=8.
- Sub-module sync_2ff: generic 1-bit two-flop synchronizer with synchronous active-high reset. The same module is reused by the soc_clk-side reset synchronizer.

Test Plan:
(Short parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=20, LOCK_STABLE_CYCLES=8.)
- Power-up: deassert reset before edge 0, pll_locked=0 -> pll_reset=1 after edges 0..2, 0 from edge 3; soc_reset=1 and pll_ok=0 throughout.
- Normal lock: pll_locked rises and is first sampled at edge k in WAIT_LOCK -> soc_reset falls and pll_ok rises at edge k+10; relock_count=0, timeout_count=0.
- Timeout: pll_locked held 0 -> exactly 20 cycles in WAIT_LOCK, then pll_reset pulses for 4 cycles; timeout_count=1 after the first attempt and 3 after three attempts.
- Glitch in STABLE: lock high 5 cycles, low 1, then high -> stays in reset; soc_reset falls 10 edges after the re-rise is sampled; no counters change.
- Lock loss in RUN: drop pll_locked -> 2 edges later pll_reset=1, soc_reset=1, pll_ok=0, relock_count=1. Repeat 300 times -> relock_count=255.
- sw_reset_req pulse in RUN, with the same pulse repeated concurrently with a lock drop -> PLL_RST each time; relock_count unchanged. Also assert reset mid-STABLE -> all outputs and counters return to their reset values.
